// File: rtl/fch_imem_ctrl.sv
// Instruction-fetch SRAM controller.
// Takes fetch requests from the IFU, reads a single-cycle-latency instruction
// SRAM and returns the words in request order through a small response FIFO.
// A request whose pc is misaligned or outside the SRAM window does not touch
// the SRAM. It returns ir = 0 with err = 1 instead.
//
// Handshake rules (both channels): a transfer happens on a rising edge where
// valid and ready are both high. The producer holds its payload steady while
// valid is high and ready is low. Ready never depends on the other side's
// valid in the same cycle, except that fl_req_vld forces fch_req_rdy low.

`ifndef RV_PC_SIZE
`define RV_PC_SIZE 32
`endif
`ifndef RV_IR_SIZE
`define RV_IR_SIZE 32
`endif

module fch_imem_ctrl #(
    parameter int ADDR_W    = 14,
    parameter int RSP_DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   fch_req_vld,
    output logic                   fch_req_rdy,
    input  logic [`RV_PC_SIZE-1:0] fch_req_pc,
    output logic                   fch_rsp_vld,
    input  logic                   fch_rsp_rdy,
    output logic [`RV_IR_SIZE-1:0] fch_rsp_ir,
    output logic                   fch_rsp_err,
    input  logic                   fl_req_vld,
    output logic                   mem_ce,
    output logic [ADDR_W-1:0]      mem_addr,
    input  logic [`RV_IR_SIZE-1:0] mem_rdata
);

    localparam int PC_W  = `RV_PC_SIZE;
    localparam int IR_W  = `RV_IR_SIZE;
    // Pointer and occupancy widths for the legal depth range 2..4.
    localparam int PTR_W = (RSP_DEPTH > 2) ? 2 : 1;
    localparam int CNT_W = (RSP_DEPTH > 3) ? 3 : 2;
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(RSP_DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(RSP_DEPTH - 1);

    // Pointer advance with wrap at the buffer depth. The depth need not be a
    // power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // ------------------------------------------------------------------
    // Request side
    // ------------------------------------------------------------------
    logic             req_hs;
    logic             req_fault;
    logic [CNT_W-1:0] pending;

    // In-flight stage: one request between the SRAM access and the FIFO push.
    logic             stage_vld;
    logic             stage_fault;
    logic             stage_drop;

    // Response FIFO state.
    logic [CNT_W-1:0] occ;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [IR_W-1:0]  fifo_ir  [RSP_DEPTH];
    logic             fifo_err [RSP_DEPTH];

    logic             push;
    logic             pop;
    logic [IR_W-1:0]  push_ir;

    // Fault decode: the pc must be word aligned and inside the SRAM window.
    always_comb begin
        req_fault = (fch_req_pc[1:0] != 2'b00) ||
                    (fch_req_pc[PC_W-1:ADDR_W+2] != '0);
    end

    // Ready comes only from registered occupancy, the in-flight bit, reset
    // and flush. A new request is accepted only when the FIFO is sure to have
    // room for its response, so the stage never has to stall.
    always_comb begin
        pending     = occ + CNT_W'(stage_vld);
        fch_req_rdy = rst_n && !fl_req_vld && (pending < DEPTH_C);
        req_hs      = fch_req_vld && fch_req_rdy;
        mem_ce      = req_hs && !req_fault;
        mem_addr    = fch_req_pc[ADDR_W+1:2];
    end

    // Capture the accepted request into the in-flight stage. The stage lives
    // for exactly the one cycle in which the SRAM returns its data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_vld   <= 1'b0;
            stage_fault <= 1'b0;
            stage_drop  <= 1'b0;
        end else if (req_hs) begin
            stage_vld   <= 1'b1;
            stage_fault <= req_fault;
            stage_drop  <= 1'b0;
        end else begin
            stage_vld   <= 1'b0;
            // Remember a flush seen while the read was in flight.
            stage_drop  <= stage_vld && fl_req_vld;
        end
    end

    // ------------------------------------------------------------------
    // Response FIFO
    // ------------------------------------------------------------------
    // A flush in the push cycle squashes the data. The stage drop bit
    // covers the same read after it has been marked.
    always_comb begin
        push    = stage_vld && !stage_drop && !fl_req_vld;
        pop     = fch_rsp_vld && fch_rsp_rdy;
        push_ir = stage_fault ? '0 : mem_rdata;
    end

    // Occupancy and pointer bookkeeping. A flush wins over any same-cycle
    // push or pop. A simultaneous push and pop leaves occupancy unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (fl_req_vld) begin
            occ    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            occ <= occ + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Data storage. The outputs are masked while the FIFO is empty, so the
    // storage itself needs no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_ir[wr_ptr]  <= push_ir;
            fifo_err[wr_ptr] <= stage_fault;
        end
    end

    // Present the head entry. The head only moves on a pop or a flush, so the
    // payload holds while the IFU stalls.
    always_comb begin
        fch_rsp_vld = (occ != '0);
        fch_rsp_ir  = fch_rsp_vld ? fifo_ir[rd_ptr]  : '0;
        fch_rsp_err = fch_rsp_vld ? fifo_err[rd_ptr] : 1'b0;
    end

endmodule

// File: tb/tb_fch_imem_ctrl.sv
// Directed testbench for fch_imem_ctrl (ADDR_W=14, RSP_DEPTH=2).
// Includes a behavioural single-cycle SRAM model.

`ifndef RV_PC_SIZE
`define RV_PC_SIZE 32
`endif
`ifndef RV_IR_SIZE
`define RV_IR_SIZE 32
`endif

module tb_fch_imem_ctrl;

    localparam int ADDR_W = 14;

    localparam logic [31:0] W0 = 32'h0000_0013;
    localparam logic [31:0] W1 = 32'h0010_0093;
    localparam logic [31:0] W2 = 32'h0020_0113;
    localparam logic [31:0] W3 = 32'h0030_0193;
    localparam logic [31:0] W4 = 32'h0040_0213;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic                   fch_req_vld = 1'b0;
    logic                   fch_req_rdy;
    logic [`RV_PC_SIZE-1:0] fch_req_pc = '0;
    logic                   fch_rsp_vld;
    logic                   fch_rsp_rdy = 1'b0;
    logic [`RV_IR_SIZE-1:0] fch_rsp_ir;
    logic                   fch_rsp_err;
    logic                   fl_req_vld = 1'b0;
    logic                   mem_ce;
    logic [ADDR_W-1:0]      mem_addr;
    logic [`RV_IR_SIZE-1:0] mem_rdata = '0;

    int n_vec = 0;
    int n_err = 0;

    fch_imem_ctrl #(.ADDR_W(ADDR_W), .RSP_DEPTH(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fch_req_vld (fch_req_vld),
        .fch_req_rdy (fch_req_rdy),
        .fch_req_pc  (fch_req_pc),
        .fch_rsp_vld (fch_rsp_vld),
        .fch_rsp_rdy (fch_rsp_rdy),
        .fch_rsp_ir  (fch_rsp_ir),
        .fch_rsp_err (fch_rsp_err),
        .fl_req_vld  (fl_req_vld),
        .mem_ce      (mem_ce),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata)
    );

    // ---------------- SRAM model ----------------
    logic [31:0] sram [2**ADDR_W];
    always @(posedge clk) begin
        if (mem_ce) mem_rdata <= sram[mem_addr];
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        fch_req_vld = 1'b1;
        fch_req_pc  = 32'h0;
        repeat (3) @(posedge clk);
        #2;
        n_vec++; if (fch_req_rdy !== 1'b0) begin n_err++; $display("FAIL rst_rdy: got %b exp 0", fch_req_rdy); end
        n_vec++; if (mem_ce !== 1'b0) begin n_err++; $display("FAIL rst_ce: got %b exp 0", mem_ce); end
        n_vec++; if (fch_rsp_vld !== 1'b0) begin n_err++; $display("FAIL rst_vld: got %b exp 0", fch_rsp_vld); end
        n_vec++; if (fch_rsp_ir !== 32'h0) begin n_err++; $display("FAIL rst_ir: got %h exp 0", fch_rsp_ir); end
        n_vec++; if (fch_rsp_err !== 1'b0) begin n_err++; $display("FAIL rst_err: got %b exp 0", fch_rsp_err); end
        fch_req_vld = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_vec++; if (fch_req_rdy !== 1'b1) begin n_err++; $display("FAIL rst_release_rdy: got %b exp 1", fch_req_rdy); end
        cycle();
    endtask

    task automatic test_basic();
        fch_rsp_rdy = 1'b1; fch_req_vld = 1'b1; fch_req_pc = 32'h0; #1;
        n_vec++; if (fch_req_rdy !== 1'b1) begin n_err++; $display("FAIL basic_rdy0: got %b exp 1", fch_req_rdy); end
        n_vec++; if (mem_ce !== 1'b1) begin n_err++; $display("FAIL basic_ce0: got %b exp 1", mem_ce); end
        n_vec++; if (mem_addr !== 14'd0) begin n_err++; $display("FAIL basic_addr0: got %h exp 0", mem_addr); end
        cycle();
        fch_req_pc = 32'h4; #1;
        n_vec++; if (mem_ce !== 1'b1) begin n_err++; $display("FAIL basic_ce1: got %b exp 1", mem_ce); end
        n_vec++; if (mem_addr !== 14'd1) begin n_err++; $display("FAIL basic_addr1: got %h exp 1", mem_addr); end
        n_vec++; if (fch_rsp_vld !== 1'b0) begin n_err++; $display("FAIL basic_early_vld: got %b exp 0", fch_rsp_vld); end
        cycle();
        fch_req_vld = 1'b0; #1;
        n_vec++; if (fch_rsp_vld !== 1'b1) begin n_err++; $display("FAIL basic_vld0: got %b exp 1", fch_rsp_vld); end
        n_vec++; if (fch_rsp_ir !== W0) begin n_err++; $display("FAIL basic_ir0: got %h exp %h", fch_rsp_ir, W0); end
        n_vec++; if (fch_rsp_err !== 1'b0) begin n_err++; $display("FAIL basic_err0: got %b exp 0", fch_rsp_err); end
        cycle(); #1;
        n_vec++; if (fch_rsp_vld !== 1'b1) begin n_err++; $display("FAIL basic_vld1: got %b exp 1", fch_rsp_vld); end
        n_vec++; if (fch_rsp_ir !== W1) begin n_err++; $display("FAIL basic_ir1: got %h exp %h", fch_rsp_ir, W1); end
        cycle(); #1;
        n_vec++; if (fch_rsp_vld !== 1'b0) begin n_err++; $display("FAIL basic_empty: got %b exp 0", fch_rsp_vld); end
        cycle();
    endtask

    task automatic test_fault();
        logic [31:0] bad_pc [2];
        bad_pc[0] = 32'h0000_0002;
        bad_pc[1] = 32'h0001_0000;
        fch_rsp_rdy = 1'b1;
        for (int i = 0; i < 2; i++) begin
            fch_req_vld = 1'b1; fch_req_pc = bad_pc[i]; #1;
            n_vec++; if (fch_req_rdy !== 1'b1) begin n_err++; $display("FAIL fault%0d_rdy: got %b exp 1", i, fch_req_rdy); end
            n_vec++; if (mem_ce !== 1'b0) begin n_err++; $display("FAIL fault%0d_ce: got %b exp 0", i, mem_ce); end
            cycle();
            fch_req_vld = 1'b0; #1;
            n_vec++; if (mem_ce !== 1'b0) begin n_err++; $display("FAIL fault%0d_ce_idle: got %b exp 0", i, mem_ce); end
            cycle(); #1;
            n_vec++; if (fch_rsp_vld !== 1'b1) begin n_err++; $display("FAIL fault%0d_vld: got %b exp 1", i, fch_rsp_vld); end
            n_vec++; if (fch_rsp_ir !== 32'h0) begin n_err++; $display("FAIL fault%0d_ir: got %h exp 0", i, fch_rsp_ir); end
            n_vec++; if (fch_rsp_err !== 1'b1) begin n_err++; $display("FAIL fault%0d_err: got %b exp 1", i, fch_rsp_err); end
            cycle(); #1;
            n_vec++; if (fch_rsp_vld !== 1'b0) begin n_err++; $display("FAIL fault%0d_empty: got %b exp 0", i, fch_rsp_vld); end
            cycle();
        end
    endtask

    task automatic test_backpressure();
        fch_rsp_rdy = 1'b0; fch_req_vld = 1'b1; fch_req_pc = 32'h0; #1;
        n_vec++; if (fch_req_rdy !== 1'b1) begin n_err++; $display("FAIL bp_rdy0: got %b exp 1", fch_req_rdy); end
        cycle();
        fch_req_pc = 32'h4; #1;
        n_vec++; if (fch_req_rdy !== 1'b1) begin n_err++; $display("FAIL bp_rdy1: got %b exp 1", fch_req_rdy); end
        cycle();
        fch_req_pc = 32'h8; #1;
        n_vec++; if (fch_req_rdy !== 1'b0) begin n_err++; $display("FAIL bp_rdy2: got %b exp 0", fch_req_rdy); end
        n_vec++; if (mem_ce !== 1'b0) begin n_err++; $display("FAIL bp_ce2: got %b exp 0", mem_ce); end
        n_vec++; if (fch_rsp_ir !== W0) begin n_err++; $display("FAIL bp_ir_a: got %h exp %h", fch_rsp_ir, W0); end
        for (int i = 0; i < 2; i++) begin
            cycle(); #1;
            n_vec++; if (fch_req_rdy !== 1'b0) begin n_err++; $display("FAIL bp_hold_rdy%0d: got %b exp 0", i, fch_req_rdy); end
            n_vec++; if (fch_rsp_vld !== 1'b1) begin n_err++; $display("FAIL bp_hold_vld%0d: got %b exp 1", i, fch_rsp_vld); end
            n_vec++; if (fch_rsp_ir !== W0) begin n_err++; $display("FAIL bp_hold_ir%0d: got %h exp %h", i, fch_rsp_ir, W0); end
        end
        fch_req_vld = 1'b0; fch_rsp_rdy = 1'b1; #1;
        n_vec++; if (fch_rsp_ir !== W0) begin n_err++; $display("FAIL bp_out0: got %h exp %h", fch_rsp_ir, W0); end
        cycle(); #1;
        n_vec++; if (fch_rsp_vld !== 1'b1) begin n_err++; $display("FAIL bp_vld1: got %b exp 1", fch_rsp_vld); end
        n_vec++; if (fch_rsp_ir !== W1) begin n_err++; $display("FAIL bp_out1: got %h exp %h", fch_rsp_ir, W1); end
        cycle(); #1;
        n_vec++; if (fch_rsp_vld !== 1'b0) begin n_err++; $display("FAIL bp_no_third: got %b exp 0", fch_rsp_vld); end
        cycle();
    endtask

    task automatic test_flush();
        fch_rsp_rdy = 1'b0; fch_req_vld = 1'b1; fch_req_pc = 32'h0; #1;
        cycle();
        fch_req_vld = 1'b0; #1;
        cycle();
        fch_req_vld = 1'b1; fch_req_pc = 32'h8; #1;
        n_vec++; if (fch_req_rdy !== 1'b1) begin n_err++; $display("FAIL fl_rdy_pre: got %b exp 1", fch_req_rdy); end
        n_vec++; if (fch_rsp_ir !== W0) begin n_err++; $display("FAIL fl_buffered: got %h exp %h", fch_rsp_ir, W0); end
        cycle();
        fch_req_vld = 1'b0; fl_req_vld = 1'b1; #1;
        n_vec++; if (fch_req_rdy !== 1'b0) begin n_err++; $display("FAIL fl_rdy_forced: got %b exp 0", fch_req_rdy); end
        n_vec++; if (fch_rsp_vld !== 1'b1) begin n_err++; $display("FAIL fl_vld_same: got %b exp 1", fch_rsp_vld); end
        cycle();
        fl_req_vld = 1'b0; #1;
        n_vec++; if (fch_rsp_vld !== 1'b0) begin n_err++; $display("FAIL fl_vld_next: got %b exp 0", fch_rsp_vld); end
        n_vec++; if (fch_req_rdy !== 1'b1) begin n_err++; $display("FAIL fl_rdy_after: got %b exp 1", fch_req_rdy); end
        fch_rsp_rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle(); #1;
            n_vec++; if (fch_rsp_vld !== 1'b0) begin n_err++; $display("FAIL fl_no_pc8_%0d: got vld %b ir %h exp vld 0", i, fch_rsp_vld, fch_rsp_ir); end
        end
        cycle();
    endtask

    task automatic test_reset_mid();
        fch_rsp_rdy = 1'b0; fch_req_vld = 1'b1; fch_req_pc = 32'h0; #1;
        cycle();
        fch_req_pc = 32'h4; #1;
        cycle();
        fch_req_vld = 1'b0; #1;
        cycle(); #1;
        n_vec++; if (fch_rsp_vld !== 1'b1) begin n_err++; $display("FAIL mrst_pre_vld: got %b exp 1", fch_rsp_vld); end
        #2 rst_n = 1'b0;
        #1;
        n_vec++; if (fch_rsp_vld !== 1'b0) begin n_err++; $display("FAIL mrst_vld: got %b exp 0", fch_rsp_vld); end
        n_vec++; if (fch_req_rdy !== 1'b0) begin n_err++; $display("FAIL mrst_rdy: got %b exp 0", fch_req_rdy); end
        n_vec++; if (fch_rsp_ir !== 32'h0) begin n_err++; $display("FAIL mrst_ir: got %h exp 0", fch_rsp_ir); end
        cycle();
        cycle();
        rst_n = 1'b1; fch_req_vld = 1'b1; fch_req_pc = 32'h0; fch_rsp_rdy = 1'b1; #1;
        n_vec++; if (fch_req_rdy !== 1'b1) begin n_err++; $display("FAIL mrst_release_rdy: got %b exp 1", fch_req_rdy); end
        cycle();
        fch_req_vld = 1'b0; #1;
        cycle(); #1;
        n_vec++; if (fch_rsp_vld !== 1'b1) begin n_err++; $display("FAIL mrst_new_vld: got %b exp 1", fch_rsp_vld); end
        n_vec++; if (fch_rsp_ir !== W0) begin n_err++; $display("FAIL mrst_new_ir: got %h exp %h", fch_rsp_ir, W0); end
        cycle(); #1;
        n_vec++; if (fch_rsp_vld !== 1'b0) begin n_err++; $display("FAIL mrst_only_one: got %b exp 0", fch_rsp_vld); end
        cycle();
    endtask

    task automatic test_wrap();
        logic [31:0] pcs [5];
        logic [31:0] exp_ir [5];
        int idx = 0;
        int k = 0;
        pcs[0] = 32'h0;  pcs[1] = 32'h4;  pcs[2] = 32'h8;  pcs[3] = 32'hC;  pcs[4] = 32'h10;
        exp_ir[0] = W0;  exp_ir[1] = W1;  exp_ir[2] = W2;  exp_ir[3] = W3;  exp_ir[4] = W4;
        fch_rsp_rdy = 1'b1;
        for (int c = 0; c < 40 && k < 5; c++) begin
            fch_req_vld = (idx < 5);
            fch_req_pc  = (idx < 5) ? pcs[idx] : 32'h0;
            #1;
            if (fch_rsp_vld === 1'b1) begin
                n_vec++;
                if (fch_rsp_ir !== exp_ir[k] || fch_rsp_err !== 1'b0) begin
                    n_err++;
                    $display("FAIL wrap_rsp%0d: got ir %h err %b exp ir %h err 0", k, fch_rsp_ir, fch_rsp_err, exp_ir[k]);
                end
                k++;
            end
            if (fch_req_vld && fch_req_rdy === 1'b1) idx++;
            cycle();
        end
        fch_req_vld = 1'b0;
        n_vec++; if (k !== 5) begin n_err++; $display("FAIL wrap_count: got %0d responses exp 5", k); end
        #1;
        n_vec++; if (fch_rsp_vld !== 1'b0) begin n_err++; $display("FAIL wrap_drain: got %b exp 0", fch_rsp_vld); end
        cycle();
    endtask

    initial begin
        for (int i = 0; i < 2**ADDR_W; i++) sram[i] = 32'hA5A5_0000 | i;
        sram[0] = W0;
        sram[1] = W1;
        sram[2] = W2;
        sram[3] = W3;
        sram[4] = W4;
        test_reset();
        test_basic();
        test_fault();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fch_imem_ctrl.md
FCH_IMEM_CTRL -- requirements
Module: fch_imem_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 14, instruction SRAM word-address width (64 KiB).
REQ-002 SHALL have parameter RSP_DEPTH, default 2, response buffer entries; legal range 2..4.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; asynchronous assert, active-low.
REQ-005 SHALL have port fch_req_vld  input  1  fetch request valid, driven by IFU.
REQ-006 SHALL have port fch_req_rdy  output  1  fetch request accept.
REQ-007 SHALL have port fch_req_pc  input  `RV_PC_SIZE  byte address of the instruction.
REQ-008 SHALL have port fch_rsp_vld  output  1  fetch response valid.
REQ-009 SHALL have port fch_rsp_rdy  input  1  IFU ready for the response.
REQ-010 SHALL have port fch_rsp_ir  output  `RV_IR_SIZE  fetched instruction word.
REQ-011 SHALL have port fch_rsp_err  output  1  access fault: misaligned or out of range.
REQ-012 SHALL have port fl_req_vld  input  1  flush pulse; discards all pending responses.
REQ-013 SHALL have port mem_ce  output  1  SRAM read enable.
REQ-014 SHALL have port mem_addr  output  ADDR_W  SRAM word address.
REQ-015 SHALL have port mem_rdata  input  `RV_IR_SIZE  SRAM data, valid exactly 1 cycle after mem_ce.

Function
REQ-016 SHALL define req handshake as fch_req_vld & fch_req_rdy, and rsp handshake as fch_rsp_vld & fch_rsp_rdy.
REQ-017 SHALL flag a request as fault when pc[1:0] != 0 or pc[`RV_PC_SIZE-1:ADDR_W+2] != 0.
REQ-018 SHALL drive mem_ce = req handshake & ~fault (combinational) and mem_addr = pc[ADDR_W+1:2].
REQ-019 SHALL hold one in-flight stage register (valid, fault, drop) set on req handshake; faulted requests occupy the stage without an SRAM access.
REQ-020 SHALL, the cycle after the stage is valid and not drop, push {mem_rdata or 0 if fault, fault} into a RSP_DEPTH-entry FIFO.
REQ-021 SHALL present the FIFO head on fch_rsp_ir/fch_rsp_err with fch_rsp_vld = (occupancy != 0); faulted entries carry ir = 0, err = 1.
REQ-022 SHALL drive fch_req_rdy = (occupancy + in-flight) < RSP_DEPTH, with no combinational path from fch_rsp_rdy or fch_rsp_* outputs; fl_req_vld SHALL also force fch_req_rdy low that cycle.
REQ-023 SHALL pop the FIFO head on rsp handshake; simultaneous push and pop SHALL leave occupancy unchanged, with data order preserved.
REQ-024 SHALL keep fch_rsp_ir/fch_rsp_err stable while fch_rsp_vld & ~fch_rsp_rdy.
REQ-025 SHALL return responses strictly in request order; at most one request is in flight.
REQ-026 SHALL, on fl_req_vld, clear FIFO occupancy at the next edge (fch_rsp_vld low next cycle), ignore any same-cycle rsp handshake, and set drop on a valid in-flight stage so its data is never pushed.
REQ-027 SHALL wrap FIFO read/write pointers modulo RSP_DEPTH; occupancy SHALL never exceed RSP_DEPTH or underflow.

Reset
REQ-028 SHALL, on rst_n low, asynchronously clear occupancy, pointers, in-flight valid/drop; fch_rsp_vld=0, fch_rsp_ir=0, fch_rsp_err=0, mem_ce=0, fch_req_rdy=0 while in reset.
REQ-029 SHALL drive fch_req_rdy=1 the first cycle after rst_n deassertion; assertion mid-operation SHALL discard all pending responses and the in-flight read.

Verification
REQ-030 SHALL verify that with mem[0]=0x00000013 and mem[1]=0x00100093, requests pc=0x0 and then pc=0x4 with fch_rsp_rdy=1 return ir 0x00000013 then 0x00100093, each 2 cycles after its request handshake.
REQ-031 SHALL verify that pc=0x2 gives mem_ce=0 and a response with err=1, ir=0; pc=0x0001_0000 (ADDR_W=14) gives the same.
REQ-032 SHALL verify that with fch_rsp_rdy=0 and 3 requests pc=0x0/0x4/0x8, exactly 2 are accepted (RSP_DEPTH=2), fch_req_rdy stays 0 with outputs stable, and releasing rdy returns responses in order.
REQ-033 SHALL verify that fl_req_vld asserted one cycle after the pc=0x8 request handshake, with 1 entry buffered, gives fch_rsp_vld=0 next cycle and never returns the pc=0x8 data.
REQ-034 SHALL verify that rst_n pulled low with 2 buffered entries drops fch_rsp_vld immediately, and after release a new pc=0x0 request returns mem[0] only.
REQ-035 SHALL verify that a push and pop in the same cycle at occupancy 1 keeps occupancy 1 and delivers entries in order across pointer wrap-around.
